// File: rtl/pri_gate_pkg.sv
// rtl/pri_gate_pkg.sv - shared state encoding and sizing helpers for the PRI gate sequencer
package pri_gate_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DELAY,
      TX,
      GUARD,
      RX
   } state_t;

   localparam int OVR_W = 8;

   // The timer is always loaded with (duration - 1), so clog2 of the longest duration is enough.
   function automatic int timer_width(input int tx_w, input int guard_w, input int rx_w,
                                      input int dly_w);
      int m;
      m = tx_w;
      if (guard_w > m) m = guard_w;
      if (rx_w > m) m = rx_w;
      if (dly_w > m) m = dly_w;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pri_gate_timer.sv
// rtl/pri_gate_timer.sv - loadable down-counter with zero flag, shared by all timed states
module pri_gate_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pri_gate_sequencer.sv
// rtl/pri_gate_sequencer.sv - per-PRI TX pulse / guard / RX gate sequencer with frame tracking
// Optional per-pulse stagger delay: define PRI_GATE_SEQUENCER_STAGGER_EN.
module pri_gate_sequencer
   import pri_gate_pkg::*;
#(
   parameter int TX_WIDTH     = 10,
   parameter int GUARD_CYCLES = 5,
   parameter int RX_WIDTH     = 200,
   parameter int MAX_PULSES   = 16,
   parameter int IDX_W        = 8,
   parameter int STAGGER_STEP = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_of_frame,
   input  logic             pulse_repetition_interval,
   input  logic             end_of_frame,
   output logic             tx_pulse,
   output logic             rx_gate,
   output logic [IDX_W-1:0] pulse_index,
   output logic             frame_active,
   output logic             frame_done,
   output logic             pri_overrun,
   output logic [OVR_W-1:0] overrun_count
);

   localparam int CNT_W = $clog2(MAX_PULSES + 1);
`ifdef PRI_GATE_SEQUENCER_STAGGER_EN
   localparam int DLY_MAX = 3 * STAGGER_STEP;
`else
   // STAGGER_STEP has no effect without the stagger build.
   localparam int DLY_MAX = 0 * STAGGER_STEP;
`endif
   localparam int TMR_W = timer_width(TX_WIDTH, GUARD_CYCLES, RX_WIDTH, DLY_MAX);

   state_t             state, state_n;
   logic [CNT_W-1:0]   count, count_n, slot;
   logic               eof_pending, eof_pending_n;
   logic [IDX_W-1:0]   pulse_index_n;
   logic               frame_active_n, frame_done_n, pri_overrun_n;
   logic [OVR_W-1:0]   overrun_count_n;
   logic               accept;
   logic               tmr_load, tmr_zero;
   logic [TMR_W-1:0]   tmr_value;
`ifdef PRI_GATE_SEQUENCER_STAGGER_EN
   logic [1:0]         slot_lo;
   logic [TMR_W-1:0]   dly;
`endif

   pri_gate_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero       (tmr_zero)
   );

   always_comb begin
      state_n         = state;
      count_n         = count;
      eof_pending_n   = eof_pending;
      pulse_index_n   = pulse_index;
      frame_active_n  = frame_active;
      frame_done_n    = 1'b0;
      pri_overrun_n   = 1'b0;
      overrun_count_n = overrun_count;
      accept          = 1'b0;
      tmr_load        = 1'b0;
      tmr_value       = '0;
      slot            = start_of_frame ? '0 : count;
`ifdef PRI_GATE_SEQUENCER_STAGGER_EN
      slot_lo         = 2'(slot);
      dly             = TMR_W'(slot_lo) * TMR_W'(STAGGER_STEP);
`endif

      // SOF restarts the frame from any state, aborting a running sequence.
      if (start_of_frame) begin
         state_n         = ARMED;
         frame_active_n  = 1'b1;
         count_n         = '0;
         overrun_count_n = '0;
         eof_pending_n   = 1'b0;
         pulse_index_n   = '0;
         accept          = pulse_repetition_interval;
      end else begin
         case (state)
            IDLE: begin
            end
            ARMED: begin
               if (pulse_repetition_interval && (count < CNT_W'(MAX_PULSES))) begin
                  accept = 1'b1;
                  if (end_of_frame) eof_pending_n = 1'b1;
               end else if (end_of_frame) begin
                  state_n        = IDLE;
                  frame_active_n = 1'b0;
                  frame_done_n   = 1'b1;
               end
            end
            default: begin
               if (pulse_repetition_interval) begin
                  pri_overrun_n = 1'b1;
                  if (overrun_count != {OVR_W{1'b1}})
                     overrun_count_n = overrun_count + OVR_W'(1);
               end
               if (end_of_frame) eof_pending_n = 1'b1;
               if (tmr_zero) begin
                  case (state)
                     DELAY: begin
                        state_n   = TX;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(TX_WIDTH - 1);
                     end
                     TX: begin
                        tmr_load = 1'b1;
                        if (GUARD_CYCLES == 0) begin
                           state_n   = RX;
                           tmr_value = TMR_W'(RX_WIDTH - 1);
                        end else begin
                           state_n   = GUARD;
                           tmr_value = TMR_W'(GUARD_CYCLES - 1);
                        end
                     end
                     GUARD: begin
                        state_n   = RX;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(RX_WIDTH - 1);
                     end
                     default: begin
                        if (eof_pending_n) begin
                           state_n        = IDLE;
                           frame_active_n = 1'b0;
                           frame_done_n   = 1'b1;
                           eof_pending_n  = 1'b0;
                        end else begin
                           state_n = ARMED;
                        end
                     end
                  endcase
               end
            end
         endcase
      end

      if (accept) begin
         pulse_index_n = IDX_W'(slot);
         count_n       = slot + CNT_W'(1);
         tmr_load      = 1'b1;
`ifdef PRI_GATE_SEQUENCER_STAGGER_EN
         if (dly != '0) begin
            state_n   = DELAY;
            tmr_value = dly - TMR_W'(1);
         end else begin
            state_n   = TX;
            tmr_value = TMR_W'(TX_WIDTH - 1);
         end
`else
         state_n   = TX;
         tmr_value = TMR_W'(TX_WIDTH - 1);
`endif
      end
   end

   // Gates are decoded from the next state so they are registered alongside it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         count         <= '0;
         eof_pending   <= 1'b0;
         tx_pulse      <= 1'b0;
         rx_gate       <= 1'b0;
         pulse_index   <= '0;
         frame_active  <= 1'b0;
         frame_done    <= 1'b0;
         pri_overrun   <= 1'b0;
         overrun_count <= '0;
      end else begin
         state         <= state_n;
         count         <= count_n;
         eof_pending   <= eof_pending_n;
         tx_pulse      <= (state_n == TX);
         rx_gate       <= (state_n == RX);
         pulse_index   <= pulse_index_n;
         frame_active  <= frame_active_n;
         frame_done    <= frame_done_n;
         pri_overrun   <= pri_overrun_n;
         overrun_count <= overrun_count_n;
      end
   end

endmodule
